// File: rtl/ahb3lite_slave_mem.sv
// rtl/ahb3lite_slave_mem.sv - AHB-Lite word RAM slave with byte lanes, wait states and ERROR response
// Optional: define AHB_SLV_SEQ_NOWAIT_EN to let SEQ burst beats skip the wait states.
module ahb3lite_slave_mem #(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DONE = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    logic [2:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          dphase_q, dphase_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic [31:0]   mem [0:(1<<AW)-1];

    logic          start;
    logic          xfer_err;
    logic          seq_beat;
    logic          need_wait;
    logic          okay_done;
    logic [3:0]    be;

`ifdef AHB_SLV_SEQ_NOWAIT_EN
    assign seq_beat = (HTRANS == 2'b11) && (HBURST != 3'b000);
`else
    logic unused_burst;
    assign unused_burst = ^{HBURST, HTRANS[0]};
    assign seq_beat     = 1'b0;
`endif

    assign need_wait = (WAIT_STATES > 0) && !seq_beat;

    assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    // New transfers are only taken in states where our own data phase is completing.
    assign start     = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign okay_done = dphase_q & HREADYOUT & ~HRESP;
    assign HRDATA    = (okay_done && !write_q) ? mem[addr_q[AW+1:2]] : 32'd0;

    always_comb begin
        xfer_err = 1'b0;
        if (HSIZE > 3'd2)                             xfer_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])                xfer_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)     xfer_err = 1'b1;
        if ((HADDR >> (AW + 2)) != 32'd0)             xfer_err = 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dphase_d = dphase_q;
        addr_d   = addr_q;
        write_d  = write_q;
        size_d   = size_q;
        if (HREADYOUT) dphase_d = start;
        if (start) begin
            addr_d  = HADDR[AW+1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
        end
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (need_wait) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            dphase_q <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dphase_q <= dphase_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            size_q   <= size_d;
        end
    end

    always_comb begin
        case (size_q[1:0])
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // RAM is deliberately not reset; combinational read makes a write visible to the next read.
    always_ff @(posedge HCLK) begin
        if (HRESETn && okay_done && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_slave_mem.sv
// tb/tb_ahb3lite_slave_mem.sv - directed bench for ahb3lite_slave_mem (instances with WAIT_STATES 0, 2, 3)
module tb_ahb3lite_slave_mem;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [2:0]        sel;
    logic              hold_low;
    logic [31:0]       haddr, hwdata;
    logic              hwrite;
    logic [2:0]        hsize, hburst;
    logic [1:0]        htrans;
    logic [2:0][31:0]  rdat;
    logic [2:0]        rdy, rsp, hready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] x_rd, x_frd;
    logic        x_frdy, x_frsp, x_lrsp;
    int          x_cyc;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hready[g] = rdy[g] & ~hold_low;
        ahb3lite_slave_mem #(.AW(10), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
            .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel[g]), .HREADY(hready[g]),
            .HADDR(haddr), .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize),
            .HBURST(hburst), .HTRANS(htrans), .HRDATA(rdat[g]),
            .HREADYOUT(rdy[g]), .HRESP(rsp[g])
        );
    end

    task automatic drive_addr(input int d, input logic [31:0] a, input logic w,
                              input logic [2:0] sz, input logic [1:0] tr, input logic [2:0] bu);
        sel = 3'b001 << d; haddr = a; hwrite = w; hsize = sz; htrans = tr; hburst = bu;
    endtask

    task automatic bus_idle();
        sel = 3'b000; haddr = 32'd0; hwrite = 1'b0; hsize = 3'd0; htrans = 2'b00; hburst = 3'd0;
    endtask

    // Single NONSEQ transfer; returns first/last data-phase samples and data-phase length.
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd);
        drive_addr(d, a, w, sz, 2'b10, 3'd0);
        @(posedge HCLK); #1;
        bus_idle(); hwdata = wd;
        @(negedge HCLK);
        x_cyc = 1; x_frdy = rdy[d]; x_frsp = rsp[d]; x_frd = rdat[d];
        while (!rdy[d] && x_cyc < 40) begin
            @(negedge HCLK); x_cyc++;
        end
        x_rd = rdat[d]; x_lrsp = rsp[d];
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        @(negedge HCLK); @(negedge HCLK);
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (rdy[d] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b expected 1", d, rdy[d]); end
            n_cmp++; if (rsp[d] !== 1'b0) begin n_err++; $display("FAIL reset_resp[%0d]: got %b expected 0", d, rsp[d]); end
            n_cmp++; if (rdat[d] !== 32'd0) begin n_err++; $display("FAIL reset_rdata[%0d]: got %h expected 0", d, rdat[d]); end
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_word_b2b();
        drive_addr(0, 32'h10, 1'b1, 3'd2, 2'b10, 3'd0);
        @(posedge HCLK); #1;
        drive_addr(0, 32'h10, 1'b0, 3'd2, 2'b10, 3'd0); hwdata = 32'hDEADBEEF;
        @(negedge HCLK);
        n_cmp++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready: got %b expected 1", rdy[0]); end
        @(posedge HCLK); #1;
        bus_idle(); hwdata = 32'd0;
        @(negedge HCLK);
        n_cmp++; if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_rd_ready: got %b expected 1", rdy[0]); end
        n_cmp++; if (rsp[0] !== 1'b0) begin n_err++; $display("FAIL b2b_rd_resp: got %b expected 0", rsp[0]); end
        n_cmp++; if (rdat[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_rdata: got %h expected deadbeef", rdat[0]); end
        @(posedge HCLK); #1;
    endtask

    task automatic test_byte_lanes();
        xfer(0, 32'h0, 1'b1, 3'd2, 32'h11223344);
        xfer(0, 32'h2, 1'b1, 3'd0, 32'h00AA0000);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h11AA3344) begin n_err++; $display("FAIL byte_write: got %h expected 11aa3344", x_rd); end
        xfer(0, 32'h0, 1'b1, 3'd1, 32'h0000BEEF);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h11AABEEF) begin n_err++; $display("FAIL half_write_lo: got %h expected 11aabeef", x_rd); end
        xfer(0, 32'h3, 1'b1, 3'd0, 32'h77000000);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h77AABEEF) begin n_err++; $display("FAIL byte3_write: got %h expected 77aabeef", x_rd); end
        xfer(0, 32'h2, 1'b1, 3'd1, 32'h55660000);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h5566BEEF) begin n_err++; $display("FAIL half_write_hi: got %h expected 5566beef", x_rd); end
    endtask

    task automatic test_wait_states();
        xfer(2, 32'h40, 1'b1, 3'd2, 32'hCAFEF00D);
        n_cmp++; if (x_cyc !== 4) begin n_err++; $display("FAIL ws3_write_cycles: got %0d expected 4", x_cyc); end
        xfer(2, 32'h40, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_cyc !== 4) begin n_err++; $display("FAIL ws3_read_cycles: got %0d expected 4", x_cyc); end
        n_cmp++; if (x_frdy !== 1'b0) begin n_err++; $display("FAIL ws3_first_ready: got %b expected 0", x_frdy); end
        n_cmp++; if (x_frd !== 32'd0) begin n_err++; $display("FAIL ws3_wait_rdata: got %h expected 0", x_frd); end
        n_cmp++; if (x_rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL ws3_rdata: got %h expected cafef00d", x_rd); end
        n_cmp++; if (x_lrsp !== 1'b0) begin n_err++; $display("FAIL ws3_resp: got %b expected 0", x_lrsp); end
    endtask

    task automatic test_burst();
        int cyc = 0;
        int done = 0;
        int beat = 1;
        int exp_cyc;
        logic r;
        logic [31:0] first_data = 32'd0;
`ifdef AHB_SLV_SEQ_NOWAIT_EN
        exp_cyc = 7;
`else
        exp_cyc = 16;
`endif
        drive_addr(2, 32'h40, 1'b0, 3'd2, 2'b10, 3'b011);
        @(posedge HCLK); #1;
        drive_addr(2, 32'h44, 1'b0, 3'd2, 2'b11, 3'b011);
        while (done < 4 && cyc < 100) begin
            @(negedge HCLK);
            cyc++; r = rdy[2];
            if (r && done == 0) first_data = rdat[2];
            if (r) done++;
            @(posedge HCLK); #1;
            if (r) begin
                beat++;
                if (beat < 4) drive_addr(2, 32'h40 + 32'(4 * beat), 1'b0, 3'd2, 2'b11, 3'b011);
                else          bus_idle();
            end
        end
        n_cmp++; if (done !== 4) begin n_err++; $display("FAIL burst_beats: got %0d expected 4", done); end
        n_cmp++; if (cyc !== exp_cyc) begin n_err++; $display("FAIL burst_cycles: got %0d expected %0d", cyc, exp_cyc); end
        n_cmp++; if (first_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL burst_beat0_data: got %h expected cafef00d", first_data); end
    endtask

    task automatic test_errors();
        xfer(0, 32'h2, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_frdy !== 1'b0) begin n_err++; $display("FAIL err_unaligned_ready1: got %b expected 0", x_frdy); end
        n_cmp++; if (x_frsp !== 1'b1) begin n_err++; $display("FAIL err_unaligned_resp1: got %b expected 1", x_frsp); end
        n_cmp++; if (x_lrsp !== 1'b1) begin n_err++; $display("FAIL err_unaligned_resp2: got %b expected 1", x_lrsp); end
        n_cmp++; if (x_cyc !== 2) begin n_err++; $display("FAIL err_unaligned_cycles: got %0d expected 2", x_cyc); end
        n_cmp++; if (x_rd !== 32'd0) begin n_err++; $display("FAIL err_rdata: got %h expected 0", x_rd); end
        xfer(0, 32'h1000, 1'b1, 3'd2, 32'hFFFFFFFF);
        n_cmp++; if (x_frsp !== 1'b1 || x_cyc !== 2) begin n_err++; $display("FAIL err_range: got resp %b cycles %0d expected 1/2", x_frsp, x_cyc); end
        xfer(0, 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF);
        n_cmp++; if (x_frsp !== 1'b1 || x_cyc !== 2) begin n_err++; $display("FAIL err_size3: got resp %b cycles %0d expected 1/2", x_frsp, x_cyc); end
        xfer(0, 32'h1, 1'b1, 3'd1, 32'hFFFFFFFF);
        n_cmp++; if (x_frsp !== 1'b1) begin n_err++; $display("FAIL err_half_odd: got %b expected 1", x_frsp); end
        xfer(0, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF);
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h5566BEEF) begin n_err++; $display("FAIL err_ram_unchanged: got %h expected 5566beef", x_rd); end
        xfer(2, 32'h2, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_cyc !== 2 || x_frsp !== 1'b1) begin n_err++; $display("FAIL err_ws3: got cycles %0d resp %b expected 2/1", x_cyc, x_frsp); end
    endtask

    task automatic test_no_xfer();
        for (int c = 0; c < 4; c++) begin
            drive_addr(0, 32'h0, 1'b1, 3'd2, (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'b10, 3'd0);
            if (c == 2) sel = 3'b000;
            if (c == 3) hold_low = 1'b1;
            @(posedge HCLK); #1;
            bus_idle(); hold_low = 1'b0; hwdata = 32'hFFFFFFFF;
            @(negedge HCLK);
            n_cmp++; if (rdy[0] !== 1'b1 || rsp[0] !== 1'b0 || rdat[0] !== 32'd0)
                begin n_err++; $display("FAIL noxfer[%0d]: got ready %b resp %b rdata %h expected 1/0/0", c, rdy[0], rsp[0], rdat[0]); end
            @(posedge HCLK); #1;
        end
        xfer(0, 32'h0, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'h5566BEEF) begin n_err++; $display("FAIL noxfer_ram: got %h expected 5566beef", x_rd); end
        n_cmp++; if (x_cyc !== 1) begin n_err++; $display("FAIL noxfer_idle_state: got %0d expected 1", x_cyc); end
    endtask

    task automatic test_reset_midwait();
        xfer(1, 32'h20, 1'b1, 3'd2, 32'hAAAA5555);
        n_cmp++; if (x_cyc !== 3) begin n_err++; $display("FAIL ws2_cycles: got %0d expected 3", x_cyc); end
        drive_addr(1, 32'h20, 1'b1, 3'd2, 2'b10, 3'd0);
        @(posedge HCLK); #1;
        bus_idle(); hwdata = 32'h0BADF00D;
        @(negedge HCLK);
        n_cmp++; if (rdy[1] !== 1'b0) begin n_err++; $display("FAIL midwait_ready: got %b expected 0", rdy[1]); end
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++; if (rdy[1] !== 1'b1) begin n_err++; $display("FAIL async_rst_ready: got %b expected 1", rdy[1]); end
        n_cmp++; if (rsp[1] !== 1'b0) begin n_err++; $display("FAIL async_rst_resp: got %b expected 0", rsp[1]); end
        n_cmp++; if (rdat[1] !== 32'd0) begin n_err++; $display("FAIL async_rst_rdata: got %h expected 0", rdat[1]); end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1, 32'h20, 1'b0, 3'd2, 32'd0);
        n_cmp++; if (x_rd !== 32'hAAAA5555) begin n_err++; $display("FAIL rst_write_dropped: got %h expected aaaa5555", x_rd); end
    endtask

    initial begin
        HRESETn = 1'b0; hold_low = 1'b0; hwdata = 32'd0;
        bus_idle();
        test_reset();
        test_word_b2b();
        test_byte_lanes();
        test_wait_states();
        test_burst();
        test_errors();
        test_no_xfer();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb3lite_slave_mem.md
Name: ahb3lite_slave_mem

Overview:
- AHB-Lite memory slave on the bus driven by the AHB-Lite master. It is the downstream consumer of HADDR/HWDATA/control; the decoder supplies its select.
- Word-organised synchronous RAM with byte-lane writes, a programmable number of wait states, and the AHB-Lite two-cycle ERROR response.
- Returns HRDATA, HREADYOUT and HRESP to the master through the HREADY mux.

Parameters:
- AW, 10, log2 of memory depth in 32-bit words (byte space = 4*2^AW).
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15).

Ports:
- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HREADY  in  1  bus-wide ready (previous transfer completing).
- HADDR  in  32  byte address.
- HWDATA  in  32  write data, valid in data phase.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; others illegal.
- HBURST  in  3  burst type; used only by the optional feature.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async on HRESETn=0): FSM=ST_IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0. RAM contents are not reset.
- Address-phase accept: a transfer is valid when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge. On that edge, register HADDR[AW+1:0], HWRITE and HSIZE, and set dphase=1.
  - IDLE and BUSY transfers, or HSEL=0, give a zero-wait OKAY: dphase=0, HREADYOUT=1, HRESP=0.
- Error check at accept. The transfer is an error if any of these hold:
  - HSIZE>2
  - HSIZE=1 and HADDR[0]=1
  - HSIZE=2 and HADDR[1:0]!=0
  - HADDR[31:AW+2] != 0 (out of range)
- FSM states:
  - ST_IDLE: HREADYOUT=1, HRESP=0. On accept:
    - error -> ST_ERR1
    - else WAIT_STATES>0 -> ST_WAIT with counter=WAIT_STATES-1
    - else stay in ST_IDLE; the data phase completes next cycle.
  - ST_WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle. At counter==0 -> ST_DONE.
  - ST_DONE: HREADYOUT=1, HRESP=0. Data phase completes. A new accept in the same cycle follows the ST_IDLE rules.
  - ST_ERR1: HREADYOUT=0, HRESP=1; always -> ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1. A new accept follows the ST_IDLE rules. If the master drives IDLE, -> ST_IDLE.
- Latency: with WAIT_STATES=N, an OKAY data phase lasts N+1 cycles. An error data phase lasts exactly 2 cycles.
- Write commit:
  - Happens on the edge that ends an OKAY data phase (HREADYOUT=1 and dphase=1).
  - Byte lanes written are selected from the registered HSIZE and address[1:0], little-endian (byte n -> HWDATA[8n+7:8n]).
  - Errored writes never modify RAM.
- Read data:
  - HRDATA = RAM[registered word address] during the final cycle of an OKAY read data phase. Full word, lane alignment is the master's job.
  - Otherwise HRDATA=0.
  - A read immediately following a write to the same word returns the newly written bytes (write-before-read ordering at the shared edge).
- Back-to-back: when HREADYOUT=1, a new address phase is accepted in the same cycle the previous data phase completes. No idle bubble.
- HREADY=0 (another slave stalling): no accept; the FSM holds ST_IDLE.
- Reset mid-transfer: the pending write is dropped and the outputs take their reset values immediately.

Optional Feature:
- Macro AHB_SLV_SEQ_NOWAIT_EN.
- Defined: wait states apply only to NONSEQ transfers. SEQ beats of INCR/INCRx/WRAPx bursts (HBURST!=0) complete zero-wait, like WAIT_STATES=0. Errors are still two-cycle.
- Undefined: every OKAY transfer, including SEQ beats, inserts WAIT_STATES waits. HBURST is ignored.

Test Plan:
- Reset: HRESETn=0 mid-wait (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously. The pending write is not committed.
- Word write/read, WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> HREADYOUT stays 1 and HRDATA=0xDEADBEEF in the read data phase.
- Byte lanes:
  - Word 0x0 holds 0x11223344.
  - Byte write 0xAA at 0x2 (HWDATA=0x00AA0000) -> read 0x0 gives 0x11AA3344.
  - Half write 0xBEEF at 0x0 -> read 0x0 gives 0x11AABEEF.
- Wait states, WAIT_STATES=3: read -> HREADYOUT low for exactly 3 cycles, then 1 with valid data. A 4-beat INCR4 burst takes 16 cycles without AHB_SLV_SEQ_NOWAIT_EN and 7 with it.
- Errors:
  - Word at 0x2 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1.
  - Address 0x1000 with AW=10 -> same two-cycle ERROR, RAM unchanged.
  - HSIZE=3 -> ERROR.
- IDLE/BUSY/HSEL=0/HREADY=0 -> zero-wait OKAY, no RAM change. The FSM stays in ST_IDLE.
